// File: rtl/snoop_coherence_ctrl.sv
// snoop_coherence_ctrl: central snoop arbiter between NUM_CORES private L1
// caches and the shared L2. It serves one coherence request at a time: it
// snoops every other core, takes data from a dirty owner or from an L2 fill,
// and answers the requester with a one-cycle response pulse.
//
// Handshakes: a request is accepted in the cycle where req_valid[i] and
// req_ready[i] are both high. req_ready is one-hot and only asserted in IDLE.
// snoop_request[i] stays high until the cycle snoop_ack[i] is seen. fill_request
// stays high until the cycle fill_ready is seen. resp_valid is a single-cycle
// pulse with no back-pressure.
module snoop_coherence_ctrl #(
    parameter int NUM_CORES     = 2,
    parameter int ADDR_WIDTH    = 64,
    parameter int DATA_WIDTH    = 64,
    parameter int SNOOP_TIMEOUT = 64
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_CORES-1:0]            req_valid,
    output logic [NUM_CORES-1:0]            req_ready,
    input  logic [NUM_CORES*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_CORES*2-1:0]          req_type,
    output logic [NUM_CORES-1:0]            resp_valid,
    output logic [DATA_WIDTH-1:0]           resp_data,
    output logic                            resp_shared,
    output logic                            resp_error,
    output logic [NUM_CORES-1:0]            snoop_request,
    output logic [ADDR_WIDTH-1:0]           snoop_addr,
    output logic                            snoop_invalidate,
    input  logic [NUM_CORES-1:0]            snoop_ack,
    input  logic [NUM_CORES-1:0]            snoop_hit,
    input  logic [NUM_CORES-1:0]            snoop_dirty,
    input  logic [NUM_CORES*DATA_WIDTH-1:0] snoop_data,
    output logic                            fill_request,
    output logic [ADDR_WIDTH-1:0]           fill_addr,
    input  logic                            fill_ready,
    input  logic [DATA_WIDTH-1:0]           fill_data
);

    localparam int ID_W  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int CNT_W = $clog2(SNOOP_TIMEOUT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SNOOP = 2'd1;
    localparam logic [1:0] S_FILL  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [1:0] T_READ_SHARED = 2'd0;
    localparam logic [1:0] T_READ_EXCL   = 2'd1;
    localparam logic [1:0] T_UPGRADE     = 2'd2;
    localparam logic [1:0] T_RESERVED    = 2'd3;

    logic [1:0]            state;
    logic [ID_W-1:0]       rr_ptr;
    logic [ID_W-1:0]       req_id;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [1:0]            type_q;
    logic [NUM_CORES-1:0]  pending;
    logic                  hit_acc;
    logic                  dirty_acc;
    logic [ID_W-1:0]       dirty_idx;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  err_q;
    logic [CNT_W-1:0]      cnt;

    logic                     grant_found;
    logic [ID_W-1:0]          grant_id;
    logic [NUM_CORES-1:0]     grant_onehot;
    logic [ADDR_WIDTH-1:0]    grant_addr;
    logic [1:0]               grant_type;
    logic [2*NUM_CORES-1:0]   req_dbl;
    logic [NUM_CORES-1:0]     req_onehot;
    logic [NUM_CORES-1:0]     ack_eff;
    logic [NUM_CORES-1:0]     pending_next;
    logic                     all_done;
    logic                     new_dirty;
    logic [ID_W-1:0]          new_idx;
    logic [DATA_WIDTH-1:0]    new_data;
    logic                     take_new;

    // Round-robin pick: rotate requests so rr_ptr sits at bit 0, take the lowest set bit.
    always_comb begin
        int w;
        grant_found  = 1'b0;
        grant_id     = '0;
        grant_onehot = '0;
        grant_addr   = '0;
        grant_type   = '0;
        w            = 0;
        req_dbl      = {req_valid, req_valid} >> rr_ptr;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (!grant_found && req_dbl[k]) begin
                grant_found = 1'b1;
                w = int'(rr_ptr) + k;
                if (w >= NUM_CORES) w = w - NUM_CORES;
                grant_id = ID_W'(w);
            end
        end
        for (int k = 0; k < NUM_CORES; k++) begin
            if (grant_found && (k == int'(grant_id))) begin
                grant_onehot[k] = 1'b1;
                grant_addr      = req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
                grant_type      = req_type[k*2 +: 2];
            end
        end
    end

    // Snoop ack bookkeeping: only pending targets count; lowest-index dirty ack supplies data.
    always_comb begin
        req_onehot = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (k == int'(req_id)) req_onehot[k] = 1'b1;
        end
        ack_eff      = (state == S_SNOOP) ? (snoop_ack & pending) : '0;
        pending_next = pending & ~ack_eff;
        all_done     = (pending_next == '0);
        new_dirty    = 1'b0;
        new_idx      = '0;
        new_data     = '0;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            if (ack_eff[k] && snoop_dirty[k]) begin
                new_dirty = 1'b1;
                new_idx   = ID_W'(k);
                new_data  = snoop_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        take_new = new_dirty && (!dirty_acc || (new_idx < dirty_idx));
    end

    // Main transaction FSM and its latched request context.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            rr_ptr    <= '0;
            req_id    <= '0;
            addr_q    <= '0;
            type_q    <= '0;
            pending   <= '0;
            hit_acc   <= 1'b0;
            dirty_acc <= 1'b0;
            dirty_idx <= '0;
            data_q    <= '0;
            err_q     <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_found) begin
                        req_id    <= grant_id;
                        addr_q    <= grant_addr;
                        type_q    <= grant_type;
                        rr_ptr    <= (int'(grant_id) == NUM_CORES - 1) ? '0 : grant_id + 1'b1;
                        hit_acc   <= 1'b0;
                        dirty_acc <= 1'b0;
                        dirty_idx <= '0;
                        data_q    <= '0;
                        cnt       <= '0;
                        if (grant_type == T_RESERVED) begin
                            err_q   <= 1'b1;
                            pending <= '0;
                            state   <= S_RESP;
                        end else begin
                            err_q   <= 1'b0;
                            pending <= ~grant_onehot;
                            state   <= S_SNOOP;
                        end
                    end
                end
                S_SNOOP: begin
                    pending <= pending_next;
                    hit_acc <= hit_acc | (|(snoop_hit & ack_eff));
                    cnt     <= cnt + 1'b1;
                    if (take_new) begin
                        dirty_acc <= 1'b1;
                        dirty_idx <= new_idx;
                        data_q    <= new_data;
                    end
                    if (all_done) begin
                        if (type_q == T_UPGRADE) begin
                            data_q <= '0;
                            state  <= S_RESP;
                        end else if (dirty_acc || new_dirty) begin
                            state <= S_RESP;
                        end else begin
                            state <= S_FILL;
                        end
                    end else if (cnt == CNT_W'(SNOOP_TIMEOUT - 1)) begin
                        err_q   <= 1'b1;
                        data_q  <= '0;
                        pending <= '0;
                        state   <= S_RESP;
                    end
                end
                S_FILL: begin
                    if (fill_ready) begin
                        data_q <= fill_data;
                        state  <= S_RESP;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs decoded from state so that reset clears every strobe one cycle later.
    always_comb begin
        req_ready = (state == S_IDLE) ? grant_onehot : '0;
        snoop_request    = (state == S_SNOOP) ? pending : '0;
        snoop_addr       = addr_q;
        fill_addr        = addr_q;
        snoop_invalidate = (state == S_SNOOP) &&
                           ((type_q == T_READ_EXCL) || (type_q == T_UPGRADE));
        fill_request     = (state == S_FILL);
        resp_valid       = (state == S_RESP) ? req_onehot : '0;
        resp_data        = (state == S_RESP) ? data_q : '0;
        resp_shared      = (state == S_RESP) && (type_q == T_READ_SHARED) && hit_acc;
        resp_error       = (state == S_RESP) && err_q;
    end

endmodule

// File: tb/tb_snoop_coherence_ctrl.sv
// Directed bench for snoop_coherence_ctrl with four cores and a short snoop
// timeout. Expected responses are queued when a request is issued and popped
// when the response pulse appears.
module tb_snoop_coherence_ctrl;

    localparam int NC = 4;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int TO = 8;
    localparam int EW = NC + 2 + DW;

    logic              clk;
    logic              rst;
    logic [NC-1:0]     req_valid;
    logic [NC-1:0]     req_ready;
    logic [NC*AW-1:0]  req_addr;
    logic [NC*2-1:0]   req_type;
    logic [NC-1:0]     resp_valid;
    logic [DW-1:0]     resp_data;
    logic              resp_shared;
    logic              resp_error;
    logic [NC-1:0]     snoop_request;
    logic [AW-1:0]     snoop_addr;
    logic              snoop_invalidate;
    logic [NC-1:0]     snoop_ack;
    logic [NC-1:0]     snoop_hit;
    logic [NC-1:0]     snoop_dirty;
    logic [NC*DW-1:0]  snoop_data;
    logic              fill_request;
    logic [AW-1:0]     fill_addr;
    logic              fill_ready;
    logic [DW-1:0]     fill_data;

    logic [EW-1:0] exp_q[$];
    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int t_acc = 0;

    snoop_coherence_ctrl #(
        .NUM_CORES(NC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SNOOP_TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_type(req_type),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .resp_shared(resp_shared), .resp_error(resp_error),
        .snoop_request(snoop_request), .snoop_addr(snoop_addr),
        .snoop_invalidate(snoop_invalidate),
        .snoop_ack(snoop_ack), .snoop_hit(snoop_hit),
        .snoop_dirty(snoop_dirty), .snoop_data(snoop_data),
        .fill_request(fill_request), .fill_addr(fill_addr),
        .fill_ready(fill_ready), .fill_data(fill_data)
    );

    // Clock and cycle counter.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Watchdog so the run always terminates.
    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [NC-1:0] oh(input int i);
        oh = NC'(1) << i;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic push_exp(input int id, input logic [DW-1:0] d, input logic sh, input logic er);
        exp_q.push_back({oh(id), er, sh, d});
    endtask

    task automatic issue(input int core, input logic [1:0] ty, input logic [AW-1:0] a);
        req_valid = '0;
        req_valid[core] = 1'b1;
        req_type[core*2 +: 2] = ty;
        req_addr[core*AW +: AW] = a;
        #1;
        chk("req_ready_onehot", 64'(req_ready), 64'(oh(core)));
        t_acc = cyc;
        step();
        req_valid = '0;
    endtask

    task automatic clear_snoop();
        snoop_ack   = '0;
        snoop_hit   = '0;
        snoop_dirty = '0;
    endtask

    // Wait (bounded) for the response pulse, compare it against the scoreboard head.
    task automatic wait_resp(input int budget, input int exp_lat, input string tag);
        logic [EW-1:0] e;
        int n;
        n = 0;
        e = '0;
        while (resp_valid == '0 && n < budget) begin
            step();
            n++;
        end
        chk({tag, "_seen"}, 64'(resp_valid != '0), 64'(1));
        chk({tag, "_q_nonempty"}, 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) e = exp_q.pop_front();
        chk({tag, "_valid"},   64'(resp_valid),  64'(e[EW-1 -: NC]));
        chk({tag, "_error"},   64'(resp_error),  64'(e[DW+1]));
        chk({tag, "_shared"},  64'(resp_shared), 64'(e[DW]));
        chk({tag, "_data"},    64'(resp_data),   64'(e[DW-1:0]));
        chk({tag, "_latency"}, 64'(cyc - t_acc), 64'(exp_lat));
        step();
        chk({tag, "_pulse"},   64'(resp_valid),  64'(0));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0; req_addr = '0; req_type = '0;
        snoop_ack = '0; snoop_hit = '0; snoop_dirty = '0; snoop_data = '0;
        fill_ready = 1'b0; fill_data = '0;
        step();
        step();

        // Reset state: every output low.
        chk("rst_req_ready",   64'(req_ready), 0);
        chk("rst_resp_valid",  64'(resp_valid), 0);
        chk("rst_resp_data",   64'(resp_data), 0);
        chk("rst_resp_shared", 64'(resp_shared), 0);
        chk("rst_resp_error",  64'(resp_error), 0);
        chk("rst_snoop_req",   64'(snoop_request), 0);
        chk("rst_snoop_addr",  64'(snoop_addr), 0);
        chk("rst_snoop_inv",   64'(snoop_invalidate), 0);
        chk("rst_fill_req",    64'(fill_request), 0);
        chk("rst_fill_addr",   64'(fill_addr), 0);
        rst = 1'b0;
        step();

        // Core0 READ_SHARED, core1 returns dirty data at T+1.
        push_exp(0, 64'hDEADBEEF_CAFEBABE, 1'b1, 1'b0);
        issue(0, 2'b00, 64'h1000);
        chk("rs_snoop_req",  64'(snoop_request), 64'(4'b1110));
        chk("rs_snoop_addr", 64'(snoop_addr), 64'h1000);
        chk("rs_snoop_inv",  64'(snoop_invalidate), 0);
        snoop_ack = 4'b1110; snoop_hit = 4'b0010; snoop_dirty = 4'b0010;
        snoop_data[1*DW +: DW] = 64'hDEADBEEF_CAFEBABE;
        step();
        clear_snoop();
        chk("rs_no_fill", 64'(fill_request), 0);
        wait_resp(3, 2, "rs_dirty");

        // Core1 READ_EXCL, all miss, L2 fill after 10 cycles.
        push_exp(1, 64'h12345678_87654321, 1'b0, 1'b0);
        issue(1, 2'b01, 64'h1000);
        chk("rx_snoop_inv", 64'(snoop_invalidate), 1);
        chk("rx_snoop_req", 64'(snoop_request), 64'(4'b1101));
        snoop_ack = 4'b1101;
        step();
        clear_snoop();
        chk("rx_fill_req",  64'(fill_request), 1);
        chk("rx_fill_addr", 64'(fill_addr), 64'h1000);
        for (int k = 0; k < 10; k++) step();
        chk("rx_fill_held", 64'(fill_request), 1);
        fill_ready = 1'b1; fill_data = 64'h12345678_87654321;
        step();
        fill_ready = 1'b0; fill_data = '0;
        wait_resp(3, 13, "rx_fill");

        // Round-robin: all cores request reserved type continuously after a fresh reset.
        do_reset();
        req_type  = 8'hFF;
        req_valid = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("arb_grant", 64'(req_ready), 64'(oh(i % NC)));
            push_exp(i % NC, 64'h0, 1'b0, 1'b1);
            t_acc = cyc;
            step();
            chk("arb_busy", 64'(req_ready), 0);
            wait_resp(3, 1, "arb");
        end
        req_valid = '0;
        req_type  = '0;

        // Core2 UPGRADE with staggered acks from cores 0, 3, 1.
        push_exp(2, 64'h0, 1'b0, 1'b0);
        issue(2, 2'b10, 64'h4000);
        chk("upg_snoop_req0", 64'(snoop_request), 64'(4'b1011));
        chk("upg_snoop_inv",  64'(snoop_invalidate), 1);
        snoop_ack = 4'b0001;
        step();
        chk("upg_snoop_req1", 64'(snoop_request), 64'(4'b1010));
        snoop_ack = 4'b1000;
        step();
        chk("upg_snoop_req2", 64'(snoop_request), 64'(4'b0010));
        snoop_ack = 4'b0010; snoop_hit = 4'b0010; snoop_dirty = 4'b0010;
        snoop_data[1*DW +: DW] = 64'hBAD0_BAD0_BAD0_BAD0;
        step();
        clear_snoop();
        wait_resp(3, 4, "upg");

        // Core0 READ_SHARED, core1 never acks: timeout; requester's own ack is ignored.
        push_exp(0, 64'h0, 1'b0, 1'b1);
        issue(0, 2'b00, 64'h2000);
        chk("tmo_snoop_req0", 64'(snoop_request), 64'(4'b1110));
        snoop_ack = 4'b1101;
        step();
        clear_snoop();
        chk("tmo_snoop_req1", 64'(snoop_request), 64'(4'b0010));
        wait_resp(12, TO + 1, "tmo");
        chk("tmo_strobes_low", 64'(snoop_request), 0);

        // Reset during FILL abandons the transaction silently.
        issue(1, 2'b00, 64'h3000);
        snoop_ack = 4'b1101;
        step();
        clear_snoop();
        chk("rstf_fill_req", 64'(fill_request), 1);
        step();
        rst = 1'b1;
        step();
        chk("rstf_fill_low",  64'(fill_request), 0);
        chk("rstf_no_resp",   64'(resp_valid), 0);
        chk("rstf_addr_zero", 64'(snoop_addr), 0);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("rstf_quiet", 64'(resp_valid | snoop_request), 0);
        end

        // Reserved type after reset: error response at T+1.
        push_exp(3, 64'h0, 1'b0, 1'b1);
        issue(3, 2'b11, 64'h5000);
        wait_resp(3, 1, "rsv");

        chk("scoreboard_empty", 64'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
